matrix_3x3_gen: RTL and testbench
=================================

Name: matrix_3x3_gen

Overview:
Builds a 3x3 pixel window from a raster-order 8-bit grey pixel stream for the median-filter path. It holds two line buffers and a 3-column shift window, and emits nine taps per input pixel. The taps feed the downstream row/column sort3 comparator stages. Control signals (vsync/href/valid) are delayed to stay aligned with the window.

Parameters:
IMG_WIDTH, 640, active pixels per line; line-buffer depth; range 3..4096
IMG_HEIGHT, 480, active lines per frame; range 3..4096
DATA_W, 8, pixel width

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
per_frame_vsync  input  1  frame sync; a rising edge marks the start of a frame
per_frame_href  input  1  line-active qualifier, pass-through only
per_img_valid  input  1  pixel strobe; one pixel per high cycle
per_img_data  input  DATA_W  pixel value
matrix_frame_vsync  output  1  per_frame_vsync delayed by 2 clk
matrix_frame_href  output  1  per_frame_href delayed by 2 clk
matrix_valid  output  1  window valid
matrix_p11..matrix_p33  output  DATA_W each (9 ports)  window taps; pRC is row R (1=oldest line), column C (1=oldest pixel)

Behaviour:
- Reset (async, rst_n=0): all outputs 0, including all nine taps, matrix_valid, vsync and href. Counters go to 0 and the FSM enters WAIT_FRAME. Line-buffer contents are don't-care.
- Coordinates:
  - x_cnt runs 0..IMG_WIDTH-1 and y_cnt runs 0..IMG_HEIGHT-1; both advance only on per_img_valid.
  - When x_cnt wraps to 0, y_cnt increments.
- FSM states: WAIT_FRAME and ACTIVE.
  - WAIT_FRAME -> ACTIVE on a per_frame_vsync rising edge (registered edge detect). Counters clear on that edge.
  - ACTIVE -> WAIT_FRAME after the pixel at x=IMG_WIDTH-1, y=IMG_HEIGHT-1 is accepted.
  - A vsync rising edge while in ACTIVE aborts the frame: counters clear and the FSM stays in ACTIVE. A partial window pipeline still drains normally.
  - per_img_valid in WAIT_FRAME is ignored: no buffer write and no matrix_valid.
- Line buffers:
  - LB1 holds line y-1 and LB2 holds line y-2, each IMG_WIDTH deep with synchronous read.
  - On an accepted pixel at column x: read LB1[x] and LB2[x], write LB1[x]=pixel, and write LB2[x]=old LB1[x]. Reads return the pre-write data.
- Window for the input pixel at (x,y): p33=(x,y), p32=(x-1,y), p31=(x-2,y), p23=(x,y-1), …, p11=(x-2,y-2). The window is bottom-right anchored; there is no centring.
- Out-of-image taps (x-k<0 or y-k<0) are 0 by default; see Optional Feature. Taps never mix columns from the previous line's tail.
- Latency: matrix_valid and the taps appear exactly 2 clk after the accepting per_img_valid cycle (stage 1: RAM read; stage 2: column shift and output register).
  - One valid out per accepted pixel, in order, with no gaps added or removed.
  - Taps hold their values when matrix_valid=0.
- Back-to-back valids and arbitrary gaps between them are both supported; window state advances only on accepted pixels.
- matrix_frame_vsync and matrix_frame_href form a 2-stage delay of their inputs, independent of valid.
- Reset mid-frame: all outputs clear immediately. After release, the block waits for the next vsync rising edge.

Optional Feature:
Macro MATRIX_BORDER_REPLICATE_EN.
- Defined: out-of-image taps take the value at the clamped coordinate (max(x-k,0), max(y-k,0)). The corner pixel (0,0) yields 9 copies of itself.
- Undefined: out-of-image taps are 0.
- Latency and port list are identical in both builds.

Test Plan:
1. Reset held, then released mid-stream with no vsync -> matrix_valid stays 0 and all taps stay 0.
2. IMG_WIDTH=4, IMG_HEIGHT=4, pixel value = 16*y+x, valid every cycle -> pixel (2,2)=0x22 produces p11=0x00, p12=0x01, p13=0x02, p21=0x10, p22=0x11, p23=0x12, p31=0x20, p32=0x21, p33=0x22, 2 clk after input.
3. Same frame, pixel (0,1)=0x10 -> default build: p23=0x00, p33=0x10, all other taps 0. MATRIX_BORDER_REPLICATE_EN build: p31=p32=p33=0x10 and p11..p23=0x00.
4. Valid toggled 1-0-1 with random gaps -> exactly 16 matrix_valid pulses per 4x4 frame, each tap set equal to the gap-free run.
5. vsync rising edge injected after 6 pixels, then a full frame -> the new frame's (0,0) window matches the fresh-frame case; no taps come from the aborted rows.
6. 17 valids in a 4x4 frame -> the 17th produces no matrix_valid (FSM in WAIT_FRAME).

Source files
------------

// File: rtl/matrix_3x3_gen.sv
// matrix_3x3_gen
//   Builds a 3x3 window from a raster-order pixel stream for the median-filter
//   path. Two line buffers supply the two previous lines; a 3-column history
//   forms the window. Nine taps come out two clocks after each accepted pixel.
//
//   Window is anchored bottom-right: p33 is the current pixel (x,y), p11 is
//   (x-2,y-2). Row 1 is the oldest line and column 1 is the oldest pixel.
//
//   Build option: define MATRIX_BORDER_REPLICATE_EN to fill out-of-image taps
//   with the nearest in-image pixel (clamped coordinate). When it is left
//   undefined, out-of-image taps read 0.
//
// Ports
//   clk, rst_n               clock, async active-low reset
//   per_frame_vsync          frame sync, a rising edge starts a frame
//   per_frame_href           line qualifier, delayed only
//   per_img_valid/_data      pixel strobe and pixel value
//   matrix_frame_vsync/href  vsync/href delayed by 2 clk
//   matrix_valid             one pulse per accepted pixel, 2 clk later
//   matrix_p11..matrix_p33   window taps, held while matrix_valid is low
module matrix_3x3_gen #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int DATA_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              per_frame_vsync,
  input  logic              per_frame_href,
  input  logic              per_img_valid,
  input  logic [DATA_W-1:0] per_img_data,
  output logic              matrix_frame_vsync,
  output logic              matrix_frame_href,
  output logic              matrix_valid,
  output logic [DATA_W-1:0] matrix_p11,
  output logic [DATA_W-1:0] matrix_p12,
  output logic [DATA_W-1:0] matrix_p13,
  output logic [DATA_W-1:0] matrix_p21,
  output logic [DATA_W-1:0] matrix_p22,
  output logic [DATA_W-1:0] matrix_p23,
  output logic [DATA_W-1:0] matrix_p31,
  output logic [DATA_W-1:0] matrix_p32,
  output logic [DATA_W-1:0] matrix_p33
);
  localparam int XW     = $clog2(IMG_WIDTH);
  localparam int YW     = $clog2(IMG_HEIGHT);
  localparam int STAGES = 2;

  typedef enum logic {WAIT_FRAME = 1'b0, ACTIVE = 1'b1} state_e;

  state_e          state_q, state_d;
  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;
  logic            vsync_q, vsync2_q, href_q, href2_q;
  logic            vs_rise, accept;
  logic [STAGES:0] vld_pipe;

  // A pixel coinciding with a vsync edge belongs to no frame and is dropped.
  assign vs_rise  = per_frame_vsync & ~vsync_q;
  assign accept   = (state_q == ACTIVE) & per_img_valid & ~vs_rise;
  assign vld_pipe[0] = accept;

  // ---------------- frame FSM and coordinates ----------------
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    if (vs_rise) begin
      state_d = ACTIVE;
      x_d     = '0;
      y_d     = '0;
    end else if (accept) begin
      if (x_q == XW'(IMG_WIDTH - 1)) begin
        x_d = '0;
        if (y_q == YW'(IMG_HEIGHT - 1)) begin
          y_d     = '0;
          state_d = WAIT_FRAME;
        end else begin
          y_d = y_q + YW'(1);
        end
      end else begin
        x_d = x_q + XW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= WAIT_FRAME;
      x_q      <= '0;
      y_q      <= '0;
      vsync_q  <= 1'b0;
      vsync2_q <= 1'b0;
      href_q   <= 1'b0;
      href2_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      vsync_q  <= per_frame_vsync;
      vsync2_q <= vsync_q;
      href_q   <= per_frame_href;
      href2_q  <= href_q;
    end
  end

  assign matrix_frame_vsync = vsync2_q;
  assign matrix_frame_href  = href2_q;

  // ---------------- line buffers (stage 1) ----------------
  // Read-before-write: LB1[x] moves down into LB2[x] as the new pixel lands.
  logic [DATA_W-1:0] lb1_mem [IMG_WIDTH];
  logic [DATA_W-1:0] lb2_mem [IMG_WIDTH];
  logic [DATA_W-1:0] lb1_rd_q, lb2_rd_q;

  always_ff @(posedge clk) begin
    if (accept) begin
      lb1_rd_q     <= lb1_mem[x_q];
      lb2_rd_q     <= lb2_mem[x_q];
      lb1_mem[x_q] <= per_img_data;
      lb2_mem[x_q] <= lb1_mem[x_q];
    end
  end

  logic [DATA_W-1:0] pix_s1_q;
  logic [XW-1:0]     x_s1_q;
  logic [YW-1:0]     y_s1_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe[STAGES:1] <= '0;
      pix_s1_q           <= '0;
      x_s1_q             <= '0;
      y_s1_q             <= '0;
    end else begin
      vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
      if (accept) begin
        pix_s1_q <= per_img_data;
        x_s1_q   <= x_q;
        y_s1_q   <= y_q;
      end
    end
  end

  // ---------------- column window (stage 2) ----------------
  // Columns are indexed by lines above the current one: [0]=y, [1]=y-1, [2]=y-2.
  logic [2:0][DATA_W-1:0]      col_new, col_a_q, col_b_q;
  logic [2:0][2:0][DATA_W-1:0] raw;     // [dy][dx], unmasked
  logic [2:0][2:0][DATA_W-1:0] taps_d;  // [row-1][col-1]
  logic [2:0][2:0][DATA_W-1:0] taps_q;
  logic [2:0]                  row_ok, col_ok;

  assign col_new = {lb2_rd_q, lb1_rd_q, pix_s1_q};

  always_comb begin
    raw = '0;
    for (int d = 0; d < 3; d++) begin
      raw[d][0] = col_new[d];
      raw[d][1] = col_a_q[d];
      raw[d][2] = col_b_q[d];
    end
  end

  // row_ok[k]: line y-k exists in this frame; col_ok[k]: column x-k is on
  // this line. The history registers may still hold the previous line's tail
  // or an aborted frame; these flags keep that data out of the window.
  assign row_ok = {(y_s1_q > YW'(1)), (y_s1_q != '0), 1'b1};
  assign col_ok = {(x_s1_q > XW'(1)), (x_s1_q != '0), 1'b1};

`ifdef MATRIX_BORDER_REPLICATE_EN
  logic [1:0] ycl, xcl;  // min(y,2), min(x,2)
  assign ycl = row_ok[2] ? 2'd2 : (row_ok[1] ? 2'd1 : 2'd0);
  assign xcl = col_ok[2] ? 2'd2 : (col_ok[1] ? 2'd1 : 2'd0);

  function automatic logic [1:0] clamp2(input logic [1:0] a, input int lim);
    return (int'(a) < lim) ? a : 2'(lim);
  endfunction
`endif

  for (genvar r = 0; r < 3; r++) begin : g_row
    for (genvar c = 0; c < 3; c++) begin : g_col
      localparam int DY = 2 - r;
      localparam int DX = 2 - c;
`ifdef MATRIX_BORDER_REPLICATE_EN
      assign taps_d[r][c] = raw[clamp2(ycl, DY)][clamp2(xcl, DX)];
`else
      assign taps_d[r][c] = (row_ok[DY] && col_ok[DX]) ? raw[DY][DX] : '0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_a_q <= '0;
      col_b_q <= '0;
      taps_q  <= '0;
    end else if (vld_pipe[1]) begin
      col_a_q <= col_new;
      col_b_q <= col_a_q;
      taps_q  <= taps_d;
    end
  end

  assign matrix_valid = vld_pipe[STAGES];
  assign matrix_p11   = taps_q[0][0];
  assign matrix_p12   = taps_q[0][1];
  assign matrix_p13   = taps_q[0][2];
  assign matrix_p21   = taps_q[1][0];
  assign matrix_p22   = taps_q[1][1];
  assign matrix_p23   = taps_q[1][2];
  assign matrix_p31   = taps_q[2][0];
  assign matrix_p32   = taps_q[2][1];
  assign matrix_p33   = taps_q[2][2];

endmodule

// File: tb/tb_matrix_3x3_gen.sv
// Directed bench for matrix_3x3_gen on a 4x4 image, pixel value 16*y+x.
module tb_matrix_3x3_gen;
  localparam int W = 4;
  localparam int H = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       vsync = 1'b0, href = 1'b0, valid = 1'b0;
  logic [7:0] data = '0;
  logic       m_vsync, m_href, m_valid;
  logic [7:0] p11, p12, p13, p21, p22, p23, p31, p32, p33;

  matrix_3x3_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .per_frame_vsync(vsync), .per_frame_href(href),
    .per_img_valid(valid), .per_img_data(data),
    .matrix_frame_vsync(m_vsync), .matrix_frame_href(m_href),
    .matrix_valid(m_valid),
    .matrix_p11(p11), .matrix_p12(p12), .matrix_p13(p13),
    .matrix_p21(p21), .matrix_p22(p22), .matrix_p23(p23),
    .matrix_p31(p31), .matrix_p32(p32), .matrix_p33(p33)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [71:0] taps;
  assign taps = {p11, p12, p13, p21, p22, p23, p31, p32, p33};

  int n_checks = 0;
  int n_fail   = 0;

  // Output capture, sampled on the falling edge.
  logic [71:0] out_q[$];
  int          out_cyc[$];
  logic [71:0] last_taps = '0;
  logic        have_last = 1'b0;
  int          hold_err = 0;

  always @(negedge clk) begin
    if (m_valid === 1'b1) begin
      out_q.push_back(taps);
      out_cyc.push_back(cyc);
      last_taps = taps;
      have_last = 1'b1;
    end else if (have_last && taps !== last_taps) begin
      hold_err++;
    end
  end

  function automatic logic [7:0] exp_tap(int x, int y, int r, int c);
    int xx, yy;
    xx = x - (3 - c);
    yy = y - (3 - r);
`ifdef MATRIX_BORDER_REPLICATE_EN
    if (xx < 0) xx = 0;
    if (yy < 0) yy = 0;
`else
    if (xx < 0 || yy < 0) return 8'h00;
`endif
    return 8'(16 * yy + xx);
  endfunction

  function automatic logic [71:0] exp_win(int x, int y);
    logic [71:0] v;
    v = '0;
    for (int r = 1; r <= 3; r++)
      for (int c = 1; c <= 3; c++)
        v = {v[63:0], exp_tap(x, y, r, c)};
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send_px(input logic [7:0] d);
    valid = 1'b1;
    data  = d;
    tick();
    valid = 1'b0;
  endtask

  task automatic vs_pulse();
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    tick();
  endtask

  task automatic clear_capture();
    out_q.delete();
    out_cyc.delete();
  endtask

  task automatic send_frame(input int gap_max);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        send_px(8'(16 * y + x));
        if (gap_max > 0) idle($urandom_range(0, gap_max));
      end
  endtask

  // Compares captured windows [base .. base+15] against a clean frame.
  task automatic check_frame(input string name, input int base);
    for (int i = 0; i < W * H; i++) begin
      n_checks++;
      if (base + i >= out_q.size()) begin
        n_fail++;
        $display("FAIL %s[%0d]: window missing, got %0d windows", name, i, out_q.size());
      end else if (out_q[base + i] !== exp_win(i % W, i / W)) begin
        n_fail++;
        $display("FAIL %s[%0d]: got %h expected %h", name, i, out_q[base + i], exp_win(i % W, i / W));
      end
    end
  endtask

  task automatic test_reset();
    valid = 1'b1;
    data  = 8'h77;
    idle(3);
    n_checks++;
    if ({m_valid, m_vsync, m_href, taps} !== 75'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected 0", {m_valid, m_vsync, m_href, taps});
    end
    valid = 1'b0;
    rst_n = 1'b1;
    clear_capture();
    for (int i = 0; i < 8; i++) send_px(8'(8'h40 + i));
    idle(4);
    n_checks++;
    if (out_q.size() !== 0) begin
      n_fail++;
      $display("FAIL no_vsync_valid: got %0d windows expected 0", out_q.size());
    end
    n_checks++;
    if ({m_valid, taps} !== 73'd0) begin
      n_fail++;
      $display("FAIL no_vsync_taps: got %h expected 0", {m_valid, taps});
    end
  endtask

  task automatic test_sync_delay();
    vsync = 1'b1;
    href  = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if ({m_vsync, m_href} !== 2'b00) begin
      n_fail++;
      $display("FAIL sync_rise_1clk: got %b expected 00", {m_vsync, m_href});
    end
    @(negedge clk);
    n_checks++;
    if ({m_vsync, m_href} !== 2'b11) begin
      n_fail++;
      $display("FAIL sync_rise_2clk: got %b expected 11", {m_vsync, m_href});
    end
    tick();
    vsync = 1'b0;
    href  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if ({m_vsync, m_href} !== 2'b11) begin
      n_fail++;
      $display("FAIL sync_fall_1clk: got %b expected 11", {m_vsync, m_href});
    end
    @(negedge clk);
    n_checks++;
    if ({m_vsync, m_href} !== 2'b00) begin
      n_fail++;
      $display("FAIL sync_fall_2clk: got %b expected 00", {m_vsync, m_href});
    end
    idle(2);
  endtask

  task automatic test_full_frame();
    int          drv_cyc;
    logic [71:0] exp01;
    drv_cyc = 0;
    clear_capture();
    vs_pulse();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        if (x == 2 && y == 2) drv_cyc = cyc;
        send_px(8'(16 * y + x));
      end
    idle(4);
    n_checks++;
    if (out_q.size() !== 16) begin
      n_fail++;
      $display("FAIL frame_count: got %0d expected 16", out_q.size());
    end
    if (out_q.size() >= 16) begin
      n_checks++;
      if (out_q[10] !== 72'h00_01_02_10_11_12_20_21_22) begin
        n_fail++;
        $display("FAIL window_2_2: got %h expected 000102101112202122", out_q[10]);
      end
      n_checks++;
      if (out_cyc[10] - drv_cyc !== 2) begin
        n_fail++;
        $display("FAIL latency_2_2: got %0d clk expected 2", out_cyc[10] - drv_cyc);
      end
`ifdef MATRIX_BORDER_REPLICATE_EN
      exp01 = 72'h00_00_00_00_00_00_10_10_10;
`else
      exp01 = 72'h00_00_00_00_00_00_00_00_10;
`endif
      n_checks++;
      if (out_q[4] !== exp01) begin
        n_fail++;
        $display("FAIL window_0_1: got %h expected %h", out_q[4], exp01);
      end
    end
    check_frame("frame", 0);
  endtask

  task automatic test_gaps();
    clear_capture();
    hold_err = 0;
    vs_pulse();
    send_frame(3);
    idle(4);
    n_checks++;
    if (out_q.size() !== 16) begin
      n_fail++;
      $display("FAIL gap_count: got %0d expected 16", out_q.size());
    end
    check_frame("gap_frame", 0);
    n_checks++;
    if (hold_err !== 0) begin
      n_fail++;
      $display("FAIL gap_hold: got %0d changes while idle expected 0", hold_err);
    end
  endtask

  task automatic test_abort();
    clear_capture();
    vs_pulse();
    for (int i = 0; i < 6; i++) send_px(8'(8'hA0 + i));
    vs_pulse();
    send_frame(0);
    idle(4);
    n_checks++;
    if (out_q.size() !== 22) begin
      n_fail++;
      $display("FAIL abort_count: got %0d expected 22", out_q.size());
    end
    check_frame("abort_frame", 6);
  endtask

  task automatic test_overflow();
    clear_capture();
    vs_pulse();
    send_frame(0);
    send_px(8'h55);
    idle(4);
    n_checks++;
    if (out_q.size() !== 16) begin
      n_fail++;
      $display("FAIL overflow_count: got %0d expected 16", out_q.size());
    end
    n_checks++;
    if (out_q.size() < 16 || out_q[15] !== exp_win(3, 3)) begin
      n_fail++;
      $display("FAIL overflow_last: got %0d windows, expected last %h", out_q.size(), exp_win(3, 3));
    end
  endtask

  task automatic test_reset_mid();
    clear_capture();
    vs_pulse();
    for (int i = 0; i < 5; i++) send_px(8'(16 * (i / W) + (i % W)));
    idle(1);
    n_checks++;
    if (taps !== exp_win(0, 1)) begin
      n_fail++;
      $display("FAIL pre_reset_taps: got %h expected %h", taps, exp_win(0, 1));
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({m_valid, m_vsync, m_href, taps} !== 75'd0) begin
      n_fail++;
      $display("FAIL async_reset: got %h expected 0", {m_valid, m_vsync, m_href, taps});
    end
    tick();
    rst_n = 1'b1;
    have_last = 1'b0;
    clear_capture();
    for (int i = 0; i < 4; i++) send_px(8'(8'h30 + i));
    idle(4);
    n_checks++;
    if (out_q.size() !== 0) begin
      n_fail++;
      $display("FAIL post_reset_wait: got %0d windows expected 0", out_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_sync_delay();
    test_full_frame();
    test_gaps();
    test_abort();
    test_overflow();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
